// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary-to-BCD converter; optional leading-zero blanking under BIN_TO_BCD_BLANK_EN
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_overflow
`ifdef BIN_TO_BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]   out_blank
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]   r_bcd;
  logic            r_ovf;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_out_bcd;
  logic            r_out_ovf;
  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_bcd_shift;
  logic            w_ovf_shift;
  logic            w_shift_en;
  logic            w_last;
  logic            w_done;
  logic            w_accept;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = w_shift_en && (r_cnt == CW'(WIDTH - 1));

`ifdef BIN_TO_BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));
  logic              r_fin;
  logic [DIGITS-1:0] r_out_blank;
  logic [DIGITS-1:0] w_blank;
  logic              w_zero;

  // the extra cycle after the last shift registers the result together with its blank mask
  assign w_shift_en = (r_state == S_SHIFT) && !r_fin;
  assign w_done     = (r_state == S_SHIFT) && r_fin;
  assign out_blank  = r_out_blank;

  // a digit blanks when it and every more significant digit are zero; the units digit never blanks
  always_comb begin
    w_blank = '0;
    w_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero     = w_zero && (r_bcd[4*i +: 4] == 4'd0);
      w_blank[i] = w_zero;
    end
  end

  // output register stage, loaded one cycle after the final iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fin       <= 1'b0;
      r_out_bcd   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_blank <= BLANK_RST;
    end else begin
      if (w_accept) begin
        r_fin <= 1'b0;
      end else if (w_last) begin
        r_fin <= 1'b1;
      end
      if (w_done) begin
        r_out_bcd   <= r_bcd;
        r_out_ovf   <= r_ovf;
        r_out_blank <= w_blank;
      end
    end
  end
`else
  assign w_shift_en = (r_state == S_SHIFT);
  assign w_done     = w_last;

  // output register, loaded with the result of the final iteration itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_bcd <= '0;
      r_out_ovf <= 1'b0;
    end else if (w_done) begin
      r_out_bcd <= w_bcd_shift;
      r_out_ovf <= r_ovf | w_ovf_shift;
    end
  end
`endif

  // add 3 to every digit >= 5; 4-bit adds, no carry between digits
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_bcd_shift = {w_adj[BW-2:0], r_bin[WIDTH-1]};
  assign w_ovf_shift = w_adj[BW-1];

  // working shift register {bcd, bin}, sticky overflow and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_bin <= in_data;
      r_bcd <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_shift_en) begin
      r_bin <= r_bin << 1;
      r_bcd <= w_bcd_shift;
      r_ovf <= r_ovf | w_ovf_shift;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic; handshake outputs decode the state register only
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_done) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign out_bcd      = r_out_bcd;
  assign out_overflow = r_out_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq (DIGITS=5 and DIGITS=4 side by side)
module tb_bin_to_bcd_seq;

  localparam int W = 16;
`ifdef BIN_TO_BCD_BLANK_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          rdy5, vld5, ovf5, rdy4, vld4, ovf4;
  logic [19:0]   bcd5;
  logic [15:0]   bcd4;
`ifdef BIN_TO_BCD_BLANK_EN
  logic [4:0]    blank5;
  logic [3:0]    blank4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy5), .in_data(in_data),
    .out_valid(vld5), .out_ready(out_ready),
    .out_bcd(bcd5), .out_overflow(ovf5)
`ifdef BIN_TO_BCD_BLANK_EN
    , .out_blank(blank5)
`endif
  );

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
    .out_valid(vld4), .out_ready(out_ready),
    .out_bcd(bcd4), .out_overflow(ovf4)
`ifdef BIN_TO_BCD_BLANK_EN
    , .out_blank(blank4)
`endif
  );

  typedef struct {
    logic [15:0] din;
    logic [19:0] bcd5;
    logic [15:0] bcd4;
    logic        ovf4;
    logic [4:0]  blank5;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint pow10(input int d);
    longint p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [39:0] ref_bcd(input longint v, input int d);
    logic [39:0] r = '0;
    longint x = v % pow10(d);
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [9:0] ref_blank(input longint v, input int d);
    logic [9:0] b = '0;
    longint m = v % pow10(d);
    for (int i = 1; i < d; i++) b[i] = (m < pow10(i));
    return b;
  endfunction

  task automatic run_one(input logic [15:0] v, input logic [19:0] e5, input logic [15:0] e4,
                         input logic eo4, input logic [4:0] eb5, input string tag);
    int cyc;
    logic [9:0] eb4;
    eb4 = ref_blank(longint'(v), 4);
    @(negedge clk);
    chk({tag, " in_ready before accept"}, 40'(rdy5 & rdy4), 40'd1);
    in_data  = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    cyc = 0;
    while (!vld5 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 40'(cyc), 40'(LAT));
    chk({tag, " valid4"}, 40'(vld4), 40'd1);
    chk({tag, " bcd5"}, 40'(bcd5), 40'(e5));
    chk({tag, " ovf5"}, 40'(ovf5), 40'd0);
    chk({tag, " bcd4"}, 40'(bcd4), 40'(e4));
    chk({tag, " ovf4"}, 40'(ovf4), 40'(eo4));
`ifdef BIN_TO_BCD_BLANK_EN
    chk({tag, " blank5"}, 40'(blank5), 40'(eb5));
    chk({tag, " blank4"}, 40'(blank4), 40'(eb4[3:0]));
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " idle after handshake"}, 40'({vld5, rdy5, vld4, rdy4}), 40'b0101);
  endtask

  initial begin
    logic [39:0] m5, m4;
    logic [9:0]  mb;
    logic [15:0] rv;
    int          highs;

    vecs[0] = '{16'd0,     20'h00000, 16'h0000, 1'b0, 5'b11110};
    vecs[1] = '{16'd65535, 20'h65535, 16'h5535, 1'b1, 5'b00000};
    vecs[2] = '{16'd12345, 20'h12345, 16'h2345, 1'b1, 5'b00000};
    vecs[3] = '{16'd9999,  20'h09999, 16'h9999, 1'b0, 5'b10000};
    vecs[4] = '{16'd10000, 20'h10000, 16'h0000, 1'b1, 5'b00000};
    vecs[5] = '{16'd42,    20'h00042, 16'h0042, 1'b0, 5'b11100};
    vecs[6] = '{16'd7,     20'h00007, 16'h0007, 1'b0, 5'b11110};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 40'(rdy5), 40'd1);
    chk("reset out_valid", 40'(vld5 | vld4), 40'd0);
    chk("reset out_bcd", 40'({bcd5, bcd4}), 40'd0);
    chk("reset overflow", 40'(ovf5 | ovf4), 40'd0);
`ifdef BIN_TO_BCD_BLANK_EN
    chk("reset blank5", 40'(blank5), 40'b11110);
    chk("reset blank4", 40'(blank4), 40'b1110);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // table vectors
    for (int i = 0; i < 7; i++) begin
      run_one(vecs[i].din, vecs[i].bcd5, vecs[i].bcd4, vecs[i].ovf4, vecs[i].blank5,
              $sformatf("vec%0d", i));
    end

    // backpressure: DONE held with out_ready low while inputs toggle
    @(negedge clk);
    in_data  = 16'd12345;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    highs = 0;
    while (!vld5 && highs < 200) begin
      @(posedge clk); #1;
      highs++;
    end
    chk("bp latency", 40'(highs), 40'(LAT));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom);
      in_data  = W'($urandom);
      chk("bp hold", 40'({vld5, rdy5, bcd5, ovf4, bcd4}), 40'({1'b1, 1'b0, 20'h12345, 1'b1, 16'h2345}));
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp no same-cycle accept", 40'({vld5, rdy5}), 40'b01);
    in_valid = 1'b0;

    // reset during the 8th SHIFT cycle aborts the conversion
    @(negedge clk);
    in_data  = 16'd4321;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", 40'(rdy5 & rdy4), 40'd1);
    chk("abort outputs", 40'({vld5, vld4, bcd5, ovf5}), 40'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (vld5 || vld4 || !rdy5) highs++;
    end
    chk("abort nothing emitted", 40'(highs), 40'd0);
    run_one(16'd7, 20'h00007, 16'h0007, 1'b0, 5'b11110, "after abort");

    // randomized values against the arithmetic reference model
    for (int i = 0; i < 30; i++) begin
      rv = (i % 3 == 0) ? 16'($urandom_range(0, 200)) : 16'($urandom);
      m5 = ref_bcd(longint'(rv), 5);
      m4 = ref_bcd(longint'(rv), 4);
      mb = ref_blank(longint'(rv), 5);
      run_one(rv, m5[19:0], m4[15:0], (rv >= 16'd10000), mb[4:0], $sformatf("rand%0d(%0d)", i, rv));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
